mem_port_arbiter: RTL and testbench

Two-requester arbiter for the single memory port of the microcoded core. The core has no stall input, so it gets every cycle it asserts a memory access. A secondary requester (debug/DMA) is buffered in a small request FIFO and uses only the cycles the core leaves idle. The block sits between the core's `mem_*` port and a synchronous SRAM with 1-cycle read latency.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core-priority SRAM port arbiter with a FIFO-buffered secondary requester
// Optional head-of-queue starvation monitor: define MEM_ARB_STARVE_EN.
package mem_port_arbiter_pkg;
   typedef logic [1:0] mem_addr_t;
endpackage

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WPTR         = 32,
   parameter int WDATA        = 32,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             core_read,
   input  logic             core_wren,
   input  logic [WPTR-1:0]  core_addr,
   input  mem_addr_t        core_size,
   input  logic [WDATA-1:0] core_wdata,
   output logic [WDATA-1:0] core_rdata,
   input  logic             sec_req,
   input  logic             sec_we,
   input  logic [WPTR-1:0]  sec_addr,
   input  mem_addr_t        sec_size,
   input  logic [WDATA-1:0] sec_wdata,
   output logic             sec_gnt,
   output logic             sec_rvalid,
   output logic [WDATA-1:0] sec_rdata,
   output logic             sec_starve,
   output logic             sram_en,
   output logic             sram_we,
   output logic [WPTR-1:0]  sram_addr,
   output mem_addr_t        sram_size,
   output logic [WDATA-1:0] sram_wdata,
   input  logic [WDATA-1:0] sram_rdata
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             fifo_we    [DEPTH];
   logic [WPTR-1:0]  fifo_addr  [DEPTH];
   mem_addr_t        fifo_size  [DEPTH];
   logic [WDATA-1:0] fifo_wdata [DEPTH];

   logic             core_act, empty, full, push, pop;
   logic             core_rd_q, sec_rd_q;
   logic [WDATA-1:0] hold_q;

   assign core_act = core_read | core_wren;
   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign sec_gnt  = !full;
   assign push     = sec_req & !full;
   // Head is taken from registered state only, so a just-accepted entry cannot issue.
   assign pop      = !core_act & !empty;

   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_size  = '0;
      sram_wdata = '0;
      if (core_act) begin
         sram_en    = 1'b1;
         sram_we    = core_wren;
         sram_addr  = core_addr;
         sram_size  = core_size;
         sram_wdata = core_wdata;
      end else if (!empty) begin
         sram_en    = 1'b1;
         sram_we    = fifo_we[rd_ptr];
         sram_addr  = fifo_addr[rd_ptr];
         sram_size  = fifo_size[rd_ptr];
         sram_wdata = fifo_wdata[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_we[wr_ptr]    <= sec_we;
         fifo_addr[wr_ptr]  <= sec_addr;
         fifo_size[wr_ptr]  <= sec_size;
         fifo_wdata[wr_ptr] <= sec_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         core_rd_q <= 1'b0;
         sec_rd_q  <= 1'b0;
         hold_q    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         core_rd_q <= core_read & !core_wren;
         sec_rd_q  <= pop & !fifo_we[rd_ptr];
         if (core_rd_q) hold_q <= sram_rdata;
      end
   end

   assign sec_rvalid = sec_rd_q;
   assign sec_rdata  = sram_rdata;
   // The core keeps seeing its own last read while secondary reads use the bus.
   assign core_rdata = core_rd_q ? sram_rdata : hold_q;

`ifdef MEM_ARB_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (empty || pop) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign sec_starve = (starve_cnt == STARVE_MAX);
`else
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT == 0);
   assign sec_starve = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Starvation expectations follow MEM_ARB_STARVE_EN.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_read, core_wren;
   logic [31:0] core_addr, core_wdata, core_rdata;
   mem_addr_t   core_size, sec_size, sram_size;
   logic        sec_req, sec_we, sec_gnt, sec_rvalid, sec_starve;
   logic [31:0] sec_addr, sec_wdata, sec_rdata;
   logic        sram_en, sram_we;
   logic [31:0] sram_addr, sram_wdata;
   logic [31:0] sram_rdata = 32'h0;

   int n_pass = 0;
   int n_total = 0;

   mem_port_arbiter #(
      .WPTR(32), .WDATA(32), .DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .core_read(core_read), .core_wren(core_wren), .core_addr(core_addr),
      .core_size(core_size), .core_wdata(core_wdata), .core_rdata(core_rdata),
      .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr), .sec_size(sec_size),
      .sec_wdata(sec_wdata), .sec_gnt(sec_gnt), .sec_rvalid(sec_rvalid),
      .sec_rdata(sec_rdata), .sec_starve(sec_starve),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_size(sram_size), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] sram_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'hDEADBEEF;
         32'h200: return 32'hCAFE0200;
         32'h300: return 32'h11111111;
         32'h400: return 32'h22222222;
         default: return a ^ 32'h5A5A0000;
      endcase
   endfunction

   // 1-cycle read latency; output garbage on non-read cycles so held data is really held.
   always @(posedge clk) begin
      if (sram_en && !sram_we) sram_rdata <= sram_word(sram_addr);
      else                     sram_rdata <= 32'hBADBAD00;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      core_read = 0; core_wren = 0; core_addr = 0; core_size = 0; core_wdata = 0;
      sec_req = 0; sec_we = 0; sec_addr = 0; sec_size = 0; sec_wdata = 0;
   endtask

   task automatic sec_rd(input logic [31:0] a);
      sec_req = 1; sec_we = 0; sec_addr = a; sec_size = 2'd1;
   endtask

   initial begin
      rst = 1;
      idle();
      #2;
      chk("rst_gnt", sec_gnt, 1);
      chk("rst_rvalid", sec_rvalid, 0);
      chk("rst_core_rdata", core_rdata, 0);
      chk("rst_starve", sec_starve, 0);
      chk("rst_sram_en_idle", sram_en, 0);
      core_read = 1; core_addr = 32'h100; #1;
      chk("rst_core_pass_en", sram_en, 1);
      chk("rst_core_pass_addr", sram_addr, 32'h100);
      core_read = 0;
      tick();
      rst = 0;

      // core read pass-through
      core_read = 1; core_addr = 32'h100; core_size = 2'd2; #2;
      chk("cr_en", sram_en, 1);
      chk("cr_addr", sram_addr, 32'h100);
      chk("cr_we", sram_we, 0);
      chk("cr_size", sram_size, 2);
      tick();
      idle(); #2;
      chk("cr_rdata", core_rdata, 32'hDEADBEEF);
      chk("cr_idle_en", sram_en, 0);
      tick();

      // uncontended secondary read
      sec_rd(32'h200); #2;
      chk("sr_gnt", sec_gnt, 1);
      chk("sr_no_bypass", sram_en, 0);
      tick();
      idle(); #2;
      chk("sr_issue_en", sram_en, 1);
      chk("sr_issue_addr", sram_addr, 32'h200);
      chk("sr_issue_size", sram_size, 1);
      chk("sr_rvalid_early", sec_rvalid, 0);
      tick();
      #2;
      chk("sr_rvalid", sec_rvalid, 1);
      chk("sr_rdata", sec_rdata, 32'hCAFE0200);
      chk("sr_core_hold", core_rdata, 32'hDEADBEEF);
      chk("sr_done_en", sram_en, 0);
      tick();

      // hold register across secondary traffic
      core_read = 1; core_addr = 32'h300; tick();
      idle(); sec_rd(32'h400); #2;
      chk("hd_core_first", core_rdata, 32'h11111111);
      tick();
      idle(); #2;
      chk("hd_issue_addr", sram_addr, 32'h400);
      chk("hd_core_mid", core_rdata, 32'h11111111);
      tick();
      #2;
      chk("hd_sec_rvalid", sec_rvalid, 1);
      chk("hd_sec_rdata", sec_rdata, 32'h22222222);
      chk("hd_core_last", core_rdata, 32'h11111111);
      tick();

      // contention: core writes 5 cycles, secondary offers 3 reads
      core_wren = 1; core_addr = 32'h500; core_wdata = 32'hA5A5A5A5;
      sec_rd(32'h200); #2;
      chk("ct0_gnt", sec_gnt, 1);
      tick();
      sec_rd(32'h100); #2;
      chk("ct1_gnt", sec_gnt, 1);
      chk("ct1_addr", sram_addr, 32'h500);
      tick();
      sec_rd(32'h300);
      for (int i = 2; i < 5; i++) begin
         #2;
         chk($sformatf("ct%0d_gnt", i), sec_gnt, 0);
         chk($sformatf("ct%0d_addr", i), sram_addr, 32'h500);
         chk($sformatf("ct%0d_we", i), sram_we, 1);
         tick();
      end
      core_wren = 0; core_addr = 0; core_wdata = 0; #2;
      chk("ct5_gnt_full", sec_gnt, 0);
      chk("ct5_issue_addr", sram_addr, 32'h200);
      chk("ct5_issue_we", sram_we, 0);
      tick();
      #2;
      chk("ct6_gnt", sec_gnt, 1);
      chk("ct6_issue_addr", sram_addr, 32'h100);
      chk("ct6_rdata", sec_rdata, 32'hCAFE0200);
      tick();
      idle(); #2;
      chk("ct7_issue_addr", sram_addr, 32'h300);
      chk("ct7_rdata", sec_rdata, 32'hDEADBEEF);
      tick();
      #2;
      chk("ct8_en", sram_en, 0);
      chk("ct8_rdata", sec_rdata, 32'h11111111);
      chk("ct8_core_hold", core_rdata, 32'h11111111);
      tick();

      // starvation monitor, limit 4
      core_wren = 1; core_addr = 32'h600; sec_rd(32'h200); tick();
      sec_req = 0;
      for (int i = 1; i < 5; i++) begin
         #2;
         chk($sformatf("sv%0d_starve", i), sec_starve, 0);
         tick();
      end
      core_wren = 0; core_addr = 0; #2;
`ifdef MEM_ARB_STARVE_EN
      chk("sv5_starve", sec_starve, 1);
`else
      chk("sv5_starve", sec_starve, 0);
`endif
      chk("sv5_issue_addr", sram_addr, 32'h200);
      tick();
      #2;
      chk("sv6_starve_clr", sec_starve, 0);
      tick();

      // reset while a secondary read is outstanding
      sec_rd(32'h200); tick();
      sec_rd(32'h100); #2;
      chk("rs_issue_addr", sram_addr, 32'h200);
      tick();
      idle(); rst = 1; #2;
      chk("rs_rvalid", sec_rvalid, 0);
      chk("rs_gnt", sec_gnt, 1);
      chk("rs_fifo_empty", sram_en, 0);
      chk("rs_core_rdata", core_rdata, 0);
      tick();
      rst = 0; #2;
      chk("rs_after_rvalid", sec_rvalid, 0);
      chk("rs_after_en", sram_en, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
